seq_detector_param: RTL and testbench

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 92 +++++++++
 tb/tb_seq_detector_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Purpose  : Serial pattern detector with a loadable pattern, overlapping or
//             non-overlapping detection and an optional saturating match
//             counter (compiled in when SEQ_DET_MATCH_CNT_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] RST_PATTERN = 4'b1010,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_value,
    input  logic             overlap_en,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                  c_FILL_W    = $clog2(PAT_W + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PAT_W);

    logic [PAT_W-1:0]    r_hist;
    logic [PAT_W-1:0]    r_pat;
    logic [c_FILL_W-1:0] r_fill;
    logic                r_out;

    logic [PAT_W-1:0]    w_hist_nxt;
    logic [c_FILL_W-1:0] w_fill_inc;
    logic                w_match;

    always_comb begin
        w_hist_nxt = {r_hist[PAT_W-2:0], in};
        w_fill_inc = (r_fill == c_FILL_FULL) ? c_FILL_FULL : r_fill + c_FILL_W'(1);
        w_match    = in_valid && !pat_load && (w_fill_inc == c_FILL_FULL)
                     && (w_hist_nxt == r_pat);
    end

    // A load discards any bit presented in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= RST_PATTERN;
            r_out  <= 1'b0;
        end else if (pat_load) begin
            r_pat  <= pat_value;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (in_valid) begin
            r_hist <= w_hist_nxt;
            r_fill <= (w_match && !overlap_en) ? '0 : w_fill_inc;
            r_out  <= w_match;
        end else begin
            r_out  <= 1'b0;
        end
    end

    assign out = r_out;

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [CNT_W-1:0] r_match_cnt;

    // A clear coincident with a match leaves that match counted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_match_cnt <= '0;
        end else if (cnt_clr) begin
            r_match_cnt <= w_match ? CNT_W'(1) : '0;
        end else if (w_match && (r_match_cnt != c_CNT_MAX)) begin
            r_match_cnt <= r_match_cnt + CNT_W'(1);
        end
    end

    assign match_cnt = r_match_cnt;
`else
    logic w_unused_cnt_clr;

    assign w_unused_cnt_clr = cnt_clr;
    assign match_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_param
//  Purpose  : Directed self-checking bench for seq_detector_param
//             (PAT_W=4, pattern 1010, CNT_W=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;
`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in;
    logic             pat_load;
    logic [PAT_W-1:0] pat_value;
    logic             overlap_en;
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    seq_detector_param #(
        .PAT_W       (PAT_W),
        .RST_PATTERN (4'b1010),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in         (in),
        .pat_load   (pat_load),
        .pat_value  (pat_value),
        .overlap_en (overlap_en),
        .cnt_clr    (cnt_clr),
        .out        (out),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ec(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in       = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        logic [5:0]  seq6;
        logic [5:0]  exp6;
        logic [11:0] seq12;
        logic [11:0] exp12;

        rst        = 1'b0;
        in_valid   = 1'b0;
        in         = 1'b0;
        pat_load   = 1'b0;
        pat_value  = '0;
        overlap_en = 1'b1;
        cnt_clr    = 1'b0;

        // Reset state and release edge
        tick();
        check("rst_out", 32'(out), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        check("rst_pat", 32'(dut.r_pat), 32'hA);
        rst = 1'b1;
        tick();
        check("rel_out", 32'(out), 32'd0);

        // Overlapping detection
        overlap_en = 1'b1;
        seq6 = 6'b101010;
        exp6 = 6'b000101;
        for (int i = 5; i >= 0; i--) begin
            send(seq6[i]);
            check($sformatf("ovl_out%0d", 5 - i), 32'(out), 32'(exp6[i]));
            if (i == 2) check("ovl_cnt1", 32'(match_cnt), ec(1));
        end
        check("ovl_cnt", 32'(match_cnt), ec(2));

        // Non-overlapping detection
        do_reset();
        overlap_en = 1'b0;
        exp6 = 6'b000100;
        for (int i = 5; i >= 0; i--) begin
            send(seq6[i]);
            check($sformatf("novl_out%0d", 5 - i), 32'(out), 32'(exp6[i]));
        end
        check("novl_cnt", 32'(match_cnt), ec(1));

        // Load with a simultaneous bit: that bit must be dropped
        pat_load  = 1'b1;
        pat_value = 4'b1101;
        in_valid  = 1'b1;
        in        = 1'b1;
        tick();
        pat_load  = 1'b0;
        in_valid  = 1'b0;
        check("load_out", 32'(out), 32'd0);
        check("load_pat", 32'(dut.r_pat), 32'hD);
        send(1'b1); check("ld_b0", 32'(out), 32'd0);
        send(1'b0); check("ld_b1", 32'(out), 32'd0);
        send(1'b1); check("ld_drop", 32'(out), 32'd0);

        // Fresh load, then 1,1,0,1 with two idle cycles between bits
        pat_load = 1'b1;
        tick();
        pat_load = 1'b0;
        send(1'b1); check("gap_b0", 32'(out), 32'd0);
        idle(); idle(); check("gap_i0", 32'(out), 32'd0);
        send(1'b1); check("gap_b1", 32'(out), 32'd0);
        idle(); idle(); check("gap_i1", 32'(out), 32'd0);
        send(1'b0); check("gap_b2", 32'(out), 32'd0);
        idle(); check("gap_i2a", 32'(out), 32'd0);
        idle(); check("gap_i2b", 32'(out), 32'd0);
        send(1'b1); check("gap_hit", 32'(out), 32'd1);
        check("gap_cnt", 32'(match_cnt), ec(2));
        idle(); check("gap_after", 32'(out), 32'd0);

        // Reset mid-stream
        send(1'b1); send(1'b0); send(1'b1);
        check("mid_pre", 32'(out), 32'd0);
        rst = 1'b0;
        #1;
        check("async_pat", 32'(dut.r_pat), 32'hA);
        check("async_cnt", 32'(match_cnt), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rel", 32'(out), 32'd0);
        send(1'b0);
        check("mid_out", 32'(out), 32'd0);
        check("mid_cnt", 32'(match_cnt), 32'd0);

        // Five overlapping matches saturate a 2-bit counter
        overlap_en = 1'b1;
        seq12 = 12'b1010_1010_1010;
        exp12 = 12'b0001_0101_0101;
        for (int i = 11; i >= 0; i--) begin
            send(seq12[i]);
            check($sformatf("sat_out%0d", 11 - i), 32'(out), 32'(exp12[i]));
        end
        check("sat_cnt", 32'(match_cnt), ec(3));

        // Clear coincident with a match, then plain clear
        send(1'b1);
        check("clr_pre", 32'(out), 32'd0);
        cnt_clr = 1'b1;
        send(1'b0);
        check("clr_hit_out", 32'(out), 32'd1);
        check("clr_hit_cnt", 32'(match_cnt), ec(1));
        idle();
        check("clr_idle_cnt", 32'(match_cnt), 32'd0);
        cnt_clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
